// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, framing constants and
// the baud divisor helper used by both uart_tx and uart_rx.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Integer-truncated divisor; callers reject results below 2.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 while enabled, pulses bit_end on
// the last count and wraps. Held at zero while disabled or cleared.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic bit_end
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] clk_cnt;

  assign bit_end = en && (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr || !en || bit_end) clk_cnt <= '0;
    else                              clk_cnt <= clk_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1, LSB first, idle-high line, all outputs registered.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD_RATE    = 9600,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_serial,
  output logic                 tx_active,
  output logic                 tx_done
);
  if (CLKS_PER_BIT < 2) begin : g_bad_cfg
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end

  tx_state_t            state;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 accept;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity;
`endif

  assign accept = (state == IDLE) && tx_start;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .en      (state != IDLE),
    .bit_end (bit_end)
  );

  // The line level for the next bit is loaded at the same edge that ends the
  // current one, so tx_serial never passes through combinational logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx_serial <= 1'b1;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      bit_idx   <= '0;
      shift     <= '0;
`ifdef UART_TX_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_serial <= 1'b1;
          if (tx_start) begin
            shift     <= tx_data;
`ifdef UART_TX_PARITY_EN
            parity    <= ^tx_data;
`endif
            state     <= START;
            tx_serial <= 1'b0;
            tx_active <= 1'b1;
          end
        end
        START: if (bit_end) begin
          state     <= DATA;
          bit_idx   <= '0;
          tx_serial <= shift[0];
        end
        DATA: if (bit_end) begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state     <= PARITY;
            tx_serial <= parity;
`else
            state     <= STOP;
            tx_serial <= 1'b1;
`endif
          end else begin
            bit_idx   <= bit_idx + 3'd1;
            shift     <= shift >> 1;
            tx_serial <= shift[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          state     <= STOP;
          tx_serial <= 1'b1;
        end
`endif
        STOP: if (bit_end) begin
          state     <= IDLE;
          tx_done   <= 1'b1;
          tx_active <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          tx_serial <= 1'b1;
          tx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: line levels sampled mid-bit against a frame
// model built from the byte value, plus latency, pulse and abort checks.
module tb_uart_tx;
  localparam int C = 7;  // 50 MHz / 7142857 baud truncates to 7
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_serial, tx_active, tx_done;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int e;

  uart_tx #(.CLK_FREQ(50000000), .BAUD_RATE(7142857)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_serial (tx_serial),
    .tx_active (tx_active),
    .tx_done   (tx_done)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (tx_done) done_cnt++;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Frame bit k of byte d: start, data LSB first, optional even parity, stop.
  function automatic int frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 0;
    if (k <= 8) return (int'(d) >> (k - 1)) & 1;
    if (NB == 11 && k == 9) return $countones(d) % 2;
    return 1;
  endfunction

  // Entered #1 after the acceptance edge; returns #1 after the tx_done edge.
  task automatic check_frame(input logic [7:0] d, input bit junk);
    int got;
    e = 0;
    for (int k = 0; k < NB; k++) begin
      repeat (k * C + C / 2 - e) @(posedge clk);
      e = k * C + C / 2;
      #1;
      chk($sformatf("bit%0d_of_%02h", k, d), int'(tx_serial), frame_bit(d, k));
      chk("active_mid", int'(tx_active), 1);
      if (junk && k == 4) begin tx_start = 1'b1; tx_data = 8'($urandom); end
      if (junk && k == 6) tx_start = 1'b0;
    end
    got = 0;
    for (int i = 0; i < 3 * C; i++) begin
      @(posedge clk); e++; #1;
      if (tx_done) begin got = 1; break; end
    end
    chk("done_seen", got, 1);
    chk("done_latency", e, NB * C);
    chk("active_at_done", int'(tx_active), 0);
    chk("serial_at_done", int'(tx_serial), 1);
    exp_done++;
  endtask

  task automatic send(input logic [7:0] d, input bit junk);
    @(negedge clk); tx_start = 1'b1; tx_data = d;
    @(posedge clk); #1;
    tx_start = 1'b0; tx_data = 8'($urandom);
    check_frame(d, junk);
  endtask

  initial begin
    int quiet;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_serial", int'(tx_serial), 1);
    chk("rst_active", int'(tx_active), 0);
    chk("rst_done", int'(tx_done), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_serial", int'(tx_serial), 1);

    send(8'hA5, 1'b0);
    send(8'hA5, 1'b1);
    send(8'h07, 1'b0);

    // tx_start held through tx_done: second frame starts with no idle gap
    @(negedge clk); tx_start = 1'b1; tx_data = 8'h00;
    @(posedge clk); #1; tx_data = 8'hFF;
    check_frame(8'h00, 1'b0);
    @(posedge clk); #1; tx_start = 1'b0;
    chk("b2b_start_bit", int'(tx_serial), 0);
    chk("b2b_active", int'(tx_active), 1);
    check_frame(8'hFF, 1'b0);

    // Reset pulse in the middle of data bit 4
    @(negedge clk); tx_start = 1'b1; tx_data = 8'hC3;
    @(posedge clk); #1; tx_start = 1'b0;
    repeat (5 * C + C / 2) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("abort_serial", int'(tx_serial), 1);
    chk("abort_active", int'(tx_active), 0);
    quiet = 1;
    for (int i = 0; i < 6 * C; i++) begin
      @(posedge clk); #1;
      if (tx_done || !tx_serial || tx_active) quiet = 0;
    end
    chk("abort_quiet", quiet, 1);
    send(8'h5A, 1'b0);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      send(8'($urandom), 1'($urandom));
    end

    repeat (2 * C) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt, exp_done);
    chk("final_idle", int'(tx_serial), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
